// File: rtl/register_file_pkg.sv
// register_file_pkg: shared CPU widths and types for decode and write-back stages
package register_file_pkg;
    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int NUM_REGS       = 2 ** REG_ADDR_WIDTH;
    typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [DATA_WIDTH-1:0]     word_t;
endpackage

// File: rtl/register_file.sv
// register_file: 2-read/1-write flop-based GPR file, register 0 hardwired to zero
module register_file #(
    parameter int DATA_WIDTH = register_file_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = register_file_pkg::REG_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] inst_read_reg_addr1,
    input  logic [ADDR_WIDTH-1:0] inst_read_reg_addr2,
    input  logic [ADDR_WIDTH-1:0] reg_wr_addr,
    input  logic [DATA_WIDTH-1:0] reg_wr_data,
    input  logic                  reg_wr,
    output logic [DATA_WIDTH-1:0] reg_file_rd_data1,
    output logic [DATA_WIDTH-1:0] reg_file_rd_data2
);
    logic [DATA_WIDTH-1:0] regs [2**ADDR_WIDTH];
    always_ff @(posedge clk) begin
        if (reset)
            regs <= '{default: '0};
        else if (reg_wr && reg_wr_addr != '0)
            regs[reg_wr_addr] <= reg_wr_data;
    end
    // r0 is forced at the read mux so it reads zero even before the first reset
    always_comb begin
        reg_file_rd_data1 = inst_read_reg_addr1 == '0 ? '0 : regs[inst_read_reg_addr1];
        reg_file_rd_data2 = inst_read_reg_addr2 == '0 ? '0 : regs[inst_read_reg_addr2];
    end
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: table-driven and sequence checks of register_file with a read scoreboard
module tb_register_file;
    logic        clk = 0;
    logic        reset;
    logic [4:0]  a1, a2, wa;
    logic [31:0] wd;
    logic        wr;
    logic [31:0] rd1, rd2;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic        rst;
        logic        wr;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] e1;
        logic [31:0] e2;
    } exp_t;

    vec_t vecs [9];
    exp_t sb [$];

    register_file dut (
        .clk                 (clk),
        .reset               (reset),
        .inst_read_reg_addr1 (a1),
        .inst_read_reg_addr2 (a2),
        .reg_wr_addr         (wa),
        .reg_wr_data         (wd),
        .reg_wr              (wr),
        .reg_file_rd_data1   (rd1),
        .reg_file_rd_data2   (rd2)
    );

    always #5 clk = ~clk;

    task automatic push(input string name, input logic [31:0] e1, input logic [31:0] e2);
        sb.push_back('{name, e1, e2});
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pop_check();
        exp_t x;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            x = sb.pop_front();
            cmp({x.name, ".rd1"}, rd1, x.e1);
            cmp({x.name, ".rd2"}, rd2, x.e2);
        end
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b1, 5'd7,  32'd20,         5'd4,  5'd7,  32'd0,          32'd20};
        vecs[1] = '{1'b0, 1'b0, 5'd7,  32'd32,         5'd4,  5'd7,  32'd0,          32'd20};
        vecs[2] = '{1'b0, 1'b0, 5'd7,  32'd32,         5'd7,  5'd7,  32'd20,         32'd20};
        vecs[3] = '{1'b0, 1'b1, 5'd0,  32'hDEADBEEF,   5'd0,  5'd0,  32'd0,          32'd0};
        vecs[4] = '{1'b0, 1'b1, 5'd31, 32'hA5A5A5A5,   5'd31, 5'd7,  32'hA5A5A5A5,   32'd20};
        vecs[5] = '{1'b0, 1'b1, 5'd1,  32'h1234,       5'd1,  5'd31, 32'h1234,       32'hA5A5A5A5};
        vecs[6] = '{1'b0, 1'b1, 5'd7,  32'hFFFFFFFF,   5'd7,  5'd0,  32'hFFFFFFFF,   32'd0};
        vecs[7] = '{1'b1, 1'b1, 5'd3,  32'd99,         5'd7,  5'd31, 32'd0,          32'd0};
        vecs[8] = '{1'b0, 1'b1, 5'd3,  32'd99,         5'd3,  5'd7,  32'd99,         32'd0};

        reset = 0; wr = 0; wa = 0; wd = 0; a1 = 0; a2 = 0;
        #1;
        push("r0_before_reset", 0, 0);
        pop_check();

        // long reset hold with a write attempted in the middle
        reset = 1;
        repeat (100) @(negedge clk);
        wr = 1; wa = 7; wd = 20; a1 = 5; a2 = 6;
        @(posedge clk); #1;
        push("reset_hold_read", 0, 0);
        pop_check();
        @(negedge clk);
        wr = 0;
        repeat (149) @(negedge clk);
        a1 = 7; a2 = 7;
        #1;
        push("reset_hold_write_dropped", 0, 0);
        pop_check();

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            reset = vecs[i].rst; wr = vecs[i].wr; wa = vecs[i].wa; wd = vecs[i].wd;
            a1 = vecs[i].a1; a2 = vecs[i].a2;
            push($sformatf("vec%0d", i), vecs[i].e1, vecs[i].e2);
            @(posedge clk); #1;
            pop_check();
        end

        // read during write: old value before the edge, new value after
        @(negedge clk);
        reset = 0; wr = 1; wa = 9; wd = 32'h55; a1 = 9; a2 = 4;
        #1;
        push("rdw_before_edge", 0, 0);
        pop_check();
        @(posedge clk); #1;
        push("rdw_after_edge", 32'h55, 0);
        pop_check();
        @(negedge clk);
        wr = 0; a2 = 9;
        #1;
        push("rdw_both_ports", 32'h55, 32'h55);
        pop_check();

        // fill 1..31, verify, then reset mid-operation
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            wr = 1; wa = 5'(i); wd = i;
        end
        @(negedge clk);
        wr = 0;
        for (int i = 1; i < 32; i++) begin
            a1 = 5'(i); a2 = 5'(32 - i);
            #1;
            push($sformatf("fill%0d", i), i, 32 - i);
            pop_check();
        end
        a1 = 31; a2 = 17;
        reset = 1; wr = 1; wa = 5; wd = 77;
        @(posedge clk); #1;
        push("midop_reset_edge", 0, 0);
        pop_check();
        @(negedge clk);
        reset = 0; wr = 0;
        for (int i = 0; i < 32; i++) begin
            a1 = 5'(i); a2 = 5'(31 - i);
            #1;
            push($sformatf("cleared%0d", i), 0, 0);
            pop_check();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- General-purpose register file for the decode stage of the 32-bit MIPS-style pipeline.
- Two independent combinational read ports feed the operand latches.
- One clocked write port is driven by write-back.
- All state is cleared by a synchronous active-high reset.

Parameters:
- DATA_WIDTH, 32, width of each register and of the data ports.
- ADDR_WIDTH, 5, register address width; number of registers is 2**ADDR_WIDTH (32).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high; clears every register.
- inst_read_reg_addr1  input  ADDR_WIDTH  read port 1 address (rs).
- inst_read_reg_addr2  input  ADDR_WIDTH  read port 2 address (rt).
- reg_wr_addr  input  ADDR_WIDTH  write address (destination register).
- reg_wr_data  input  DATA_WIDTH  write data.
- reg_wr  input  1  write enable, active-high.
- reg_file_rd_data1  output  DATA_WIDTH  contents of register inst_read_reg_addr1.
- reg_file_rd_data2  output  DATA_WIDTH  contents of register inst_read_reg_addr2.

Behaviour:
- Storage: 2**ADDR_WIDTH registers of DATA_WIDTH bits, flop-based; no memory macro.
- One clock; reset is synchronous and active-high.
  - On a rising clk edge with reset=1, all registers become 0.
  - Reset has priority over a write in the same cycle; the write is dropped.
  - A write attempted at any edge while reset is held is ignored. Holding reset for many cycles keeps the file all-zero.
- Write: on a rising clk edge with reset=0 and reg_wr=1, register[reg_wr_addr] <= reg_wr_data. With reg_wr=0, no register changes.
- Register 0 is hardwired to zero:
  - Writes to address 0 are discarded.
  - Reads of address 0 always return 0, independent of reset history.
- Read: purely combinational; reg_file_rd_data1/2 = register[addr1/addr2]; zero-cycle latency from an address change.
  - Both ports may address the same register simultaneously; both return the same value.
- Read during write, same address: no internal bypass.
  - Before the edge, the read returns the old value.
  - After the edge, it returns the newly written value.
  - Forwarding is the pipeline's job.
- Output reset values: after the first reset edge, both outputs are 0 for every address until a write occurs.
- Before any reset, contents other than register 0 are undefined (X in simulation).
- Reset asserted mid-operation: takes effect at the next rising edge. All previously written values are lost; outputs read 0 combinationally from that edge.
- No handshake and no stall; one write accepted per cycle.

Decomposition:
- Shared package (e.g. cpu_pkg) holds DATA_WIDTH=32, REG_ADDR_WIDTH=5, NUM_REGS=32 and a reg_addr_t/word_t typedef. Decode and write-back stages use the same package.
- No sub-module; a single flat module with one always_ff for reset/write and two combinational read muxes.

Test Plan:
- Reset hold: reset=1 for 250 cycles; at an edge during reset, apply reg_wr=1, reg_wr_addr=7, reg_wr_data=20 and read addr1=5, addr2=6 -> both reads 0. Then read addr 7 -> still 0 (write suppressed by reset).
- Basic write/read: after reset=0, write reg 7 = 20 with reg_wr=1 for one edge. Set addr1=4, addr2=7 -> rd_data1=0, rd_data2=20.
- Write-enable low: reg_wr=0, reg_wr_addr=7, reg_wr_data=32 over several edges -> rd_data2 at addr 7 stays 20.
- Register 0: write reg 0 = 0xDEADBEEF with reg_wr=1 -> reading addr 0 on either port returns 0.
- Read-during-write: addr1=9 while writing reg 9 = 0x55 -> rd_data1 shows 0 before the edge and 0x55 immediately after it. Both ports at addr 9 -> both 0x55.
- Reset mid-operation: write regs 1..31 with value = index, verify each, assert reset for one edge -> all 32 addresses read 0 on both ports.
